// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed hex display: blank segment pattern
// and scanner FSM state encodings.
package display_pkg;

  // Active-low segments a..g, index 0 is segment a; all ones is dark.
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  typedef enum logic {
    GUARD = 1'b0,
    SCAN  = 1'b1
  } state_t;

endpackage

// File: rtl/hex_display_scanner_if.sv
// Host-side bus of the display scanner: frame load strobe plus scan outputs.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = $clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    pending;
  logic                    frame_tick;
  logic [IW-1:0]           digit_idx;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [0:6]              seg;

  modport master (
    output load, data_in, blank_in,
    input  pending, frame_tick, digit_idx, digit_en, seg
  );

  modport slave (
    input  load, data_in, blank_in,
    output pending, frame_tick, digit_idx, digit_en, seg
  );
endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern (index 0 = segment a).
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [0:6] seg
);

  // Purely combinational lookup; the caller registers the result.
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display scanner with a double-buffered frame, an
// all-dark guard at the start of every digit slot, per-digit blanking and
// optional leading-zero suppression.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int LZ_SUPPRESS  = 0
) (
  input logic                   clk,
  input logic                   rst,
  hex_display_scanner_if.slave  bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic                    wrap, tick;

  logic [4*NUM_DIGITS-1:0] sh_d, act_d, act_d_nx;
  logic [NUM_DIGITS-1:0]   sh_b, act_b, act_b_nx;
  logic                    pend;

  logic [NUM_DIGITS-1:0]   lz, dark_mask, en_nx, en_q;
  logic                    hi_zero, dark;
  logic [3:0]              nib;
  logic [0:6]              dec, seg_q;

  // Last SCAN cycle of the last digit: frame boundary.
  assign wrap = (state == SCAN) && (cnt == CW'(PRESCALE - 1)) &&
                (idx == IW'(NUM_DIGITS - 1));

  // FSM state, slot counter, digit index and frame tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GUARD;
      cnt   <= '0;
      idx   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      tick  <= wrap;
    end
  end

  // Next state: guard for GUARD_CYCLES, scan for the rest of the slot.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    case (state)
      GUARD: if (cnt == CW'(GUARD_CYCLES - 1)) state_nx = SCAN;
      SCAN: begin
        if (cnt == CW'(PRESCALE - 1)) begin
          state_nx = GUARD;
          cnt_nx   = '0;
          idx_nx   = wrap ? '0 : idx + IW'(1);
        end
      end
      default: state_nx = GUARD;
    endcase
  end

  // Shadow/active frame buffer; the active copy only changes on a wrap, so
  // a load in the wrap cycle leaves its data pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_d  <= '0;
      sh_b  <= '0;
      act_d <= '0;
      act_b <= '0;
      pend  <= 1'b0;
    end else begin
      if (wrap && pend) begin
        act_d <= sh_d;
        act_b <= sh_b;
      end
      if (bus.load) begin
        sh_d <= bus.data_in;
        sh_b <= bus.blank_in;
      end
      pend <= bus.load ? 1'b1 : (wrap ? 1'b0 : pend);
    end
  end

  // Outputs are computed from next-cycle state so the registered enables
  // and segments line up with the FSM and digit index, with no skew.
  always_comb begin
    act_d_nx = (wrap && pend) ? sh_d : act_d;
    act_b_nx = (wrap && pend) ? sh_b : act_b;
    hi_zero  = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (act_d_nx[4*i +: 4] == 4'h0);
      lz[i]   = (LZ_SUPPRESS != 0) && (i > 0) && hi_zero;
    end
    dark_mask = act_b_nx | lz;
    nib       = act_d_nx[{idx_nx, 2'b00} +: 4];
    dark      = (state_nx == GUARD) || dark_mask[idx_nx];
    en_nx     = '1;
    if (!dark) en_nx[idx_nx] = 1'b0;
  end

  hex7seg u_dec (
    .nib (nib),
    .seg (dec)
  );

  // Registered anode enables and segments, updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '1;
      seg_q <= SEG_OFF;
    end else begin
      en_q  <= en_nx;
      seg_q <= dark ? SEG_OFF : dec;
    end
  end

  assign bus.digit_en   = en_q;
  assign bus.seg        = seg_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_tick = tick;
  assign bus.pending    = pend;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboarded bench: two scanners (leading-zero suppression off and on)
// share stimulus; a timeline reference model predicts every cycle.
module tb_hex_display_scanner;
  import display_pkg::*;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int G  = 2;
  localparam int FR = N * P;

  // Per-segment "lit" sets over the 16 hex values (bit v = value v).
  localparam logic [15:0] ON_A = 16'hD7ED;
  localparam logic [15:0] ON_B = 16'h279F;
  localparam logic [15:0] ON_C = 16'h2FFB;
  localparam logic [15:0] ON_D = 16'h7B6D;
  localparam logic [15:0] ON_E = 16'hFD45;
  localparam logic [15:0] ON_F = 16'hDF71;
  localparam logic [15:0] ON_G = 16'hEF7C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  bin = '0;

  always #5 clk = ~clk;

  hex_display_scanner_if #(.NUM_DIGITS(N)) if0 ();
  hex_display_scanner_if #(.NUM_DIGITS(N)) if1 ();

  assign if0.load = load;  assign if0.data_in = din;  assign if0.blank_in = bin;
  assign if1.load = load;  assign if1.data_in = din;  assign if1.blank_in = bin;

  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD_CYCLES(G), .LZ_SUPPRESS(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD_CYCLES(G), .LZ_SUPPRESS(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int         t;
    logic [3:0] en0, en1;
    logic [0:6] seg0, seg1;
    logic [1:0] idx;
    logic       pend, tick;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [0:6] ref_seg(input logic [3:0] n);
    logic [0:6] r;
    r[0] = ~ON_A[n]; r[1] = ~ON_B[n]; r[2] = ~ON_C[n]; r[3] = ~ON_D[n];
    r[4] = ~ON_E[n]; r[5] = ~ON_F[n]; r[6] = ~ON_G[n];
    return r;
  endfunction

  // Expected display at cycle t (cycles since reset release) for a frame.
  function automatic void ref_out(input int t, input logic [15:0] d, input logic [3:0] b,
                                  input bit lz, output logic [3:0] en, output logic [0:6] s);
    int slot = (t / P) % N;
    int ph   = t % P;
    logic [3:0] nib = d[4*slot +: 4];
    bit dark = (ph < G) || b[slot] || (lz && slot > 0 && (d >> (4*slot)) == 16'h0);
    en = 4'hF;
    s  = SEG_OFF;
    if (!dark) begin
      en[slot] = 1'b0;
      s = ref_seg(nib);
    end
  endfunction

  // Reference model: frame content switches at multiples of N*P cycles.
  initial begin : model
    int t;
    logic [15:0] sd, ad;
    logic [3:0]  sb, ab;
    logic        pd;
    exp_t        e;
    t = 0; sd = '0; ad = '0; sb = '0; ab = '0; pd = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; sd = '0; ad = '0; sb = '0; ab = '0; pd = 1'b0;
        q.delete();
      end else begin
        if (((t + 1) % FR) == 0 && pd) begin
          ad = sd; ab = sb; pd = 1'b0;
        end
        if (load) begin
          sd = din; sb = bin; pd = 1'b1;
        end
        t++;
        e.t = t;
        ref_out(t, ad, ab, 1'b0, e.en0, e.seg0);
        ref_out(t, ad, ab, 1'b1, e.en1, e.seg1);
        e.idx  = 2'((t / P) % N);
        e.pend = pd;
        e.tick = (t % FR) == 0;
        q.push_back(e);
      end
    end
  end

  // Monitor: compares both DUTs against the queued expectation each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
        end else begin
          e = q.pop_front();
          vectors++;
          if (if0.digit_en !== e.en0 || if0.seg !== e.seg0 || if0.digit_idx !== e.idx ||
              if0.pending !== e.pend || if0.frame_tick !== e.tick) begin
            miscompares++;
            $display("FAIL scan_lz0 t=%0d got en=%b seg=%b idx=%0d pend=%b tick=%b want en=%b seg=%b idx=%0d pend=%b tick=%b",
                     e.t, if0.digit_en, if0.seg, if0.digit_idx, if0.pending, if0.frame_tick,
                     e.en0, e.seg0, e.idx, e.pend, e.tick);
          end
          vectors++;
          if (if1.digit_en !== e.en1 || if1.seg !== e.seg1 || if1.digit_idx !== e.idx ||
              if1.pending !== e.pend || if1.frame_tick !== e.tick) begin
            miscompares++;
            $display("FAIL scan_lz1 t=%0d got en=%b seg=%b idx=%0d pend=%b tick=%b want en=%b seg=%b idx=%0d pend=%b tick=%b",
                     e.t, if1.digit_en, if1.seg, if1.digit_idx, if1.pending, if1.frame_tick,
                     e.en1, e.seg1, e.idx, e.pend, e.tick);
          end
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    @(negedge clk);
    load = 1'b1; din = d; bin = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      @(negedge clk);
      if (if0.frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL frame_tick_timeout got none within %0d cycles want one", 2 * FR);
    end
  endtask

  task automatic reset_mid_scan();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * P && !seen; i++) begin
      @(negedge clk);
      if (if0.digit_en != 4'hF) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL scan_start_timeout got no lit digit want one within %0d cycles", 2 * P);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (if0.digit_en !== 4'hF || if0.seg !== SEG_OFF) begin
      miscompares++;
      $display("FAIL async_reset_lz0 got en=%b seg=%b want en=1111 seg=1111111", if0.digit_en, if0.seg);
    end
    vectors++;
    if (if1.digit_en !== 4'hF || if1.seg !== SEG_OFF || if1.pending !== 1'b0 || if1.frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_lz1 got en=%b seg=%b pend=%b tick=%b want 1111 1111111 0 0",
               if1.digit_en, if1.seg, if1.pending, if1.frame_tick);
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] d;
    logic [3:0]  b;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_tick(); wait_tick();
    reset_mid_scan();
    wait_tick();

    repeat (10) @(negedge clk);
    do_load(16'h1234, 4'b0000);
    wait_tick(); wait_tick();

    do_load(16'h0050, 4'b0000);
    wait_tick(); wait_tick();

    do_load(16'h8888, 4'b0100);
    wait_tick(); wait_tick();

    // Load A two cycles before the wrap, then B in the wrap cycle itself.
    wait_tick();
    repeat (28) @(negedge clk);
    do_load(16'hABCD, 4'b0000);
    do_load(16'h0F37, 4'b0010);
    wait_tick(); wait_tick(); wait_tick();

    for (int k = 0; k < 14; k++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 4));
      b = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      do_load(d, b);
      if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'b0000);
      wait_tick(); wait_tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
